// File: rtl/minisrc_pkg.sv
// Shared types and default sizes for the Mini SRC memory-port logic.
package minisrc_pkg;

  // Default RAM geometry: 512 words of 32 bits.
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  // Port identifiers used by the arbiter and the access latch.
  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick with its last-grant pointer.
// On a tie the port that did not win last time is chosen.
module rr_arb2
  import minisrc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_c,
  input  logic i_req_d,
  input  logic i_take,
  output logic o_valid,
  output logic o_port
);

  // Port granted most recently; reset to D so the CPU wins the first tie.
  logic r_last;

  // Combinational winner selection.
  always_comb begin
    o_valid = i_req_c | i_req_d;
    o_port  = PORT_C;
    if (i_req_c && i_req_d) begin
      o_port = ~r_last;
    end else if (i_req_d) begin
      o_port = PORT_D;
    end
  end

  // Pointer moves to the winner whenever a request is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= PORT_D;
    end else if (i_take && o_valid) begin
      r_last <= o_port;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU (C) and debug/loader (D)
// ports. Each access takes three cycles: IDLE (sample), ACC (strobe +
// grant), RSP (done + read-data return).
module mem_port_arbiter
  import minisrc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  // Debug/loader port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  // RAM side
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next;
  logic              w_sample;
  logic              w_valid;
  logic              w_port;
  logic              r_we;
  logic              r_port;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_rd_rsp;

  assign w_sample = (r_state == ST_IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req_c (c_req),
    .i_req_d (d_req),
    .i_take  (w_sample),
    .o_valid (w_valid),
    .o_port  (w_port)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: any sampled request starts an access, then ACC->RSP->IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_valid) w_next = ST_ACC;
      ST_ACC:  w_next = ST_RSP;
      ST_RSP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Latch the winner's request on the IDLE->ACC edge; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_port  <= PORT_C;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_sample && w_valid) begin
      r_port  <= w_port;
      r_we    <= (w_port == PORT_D) ? d_we    : c_we;
      r_addr  <= (w_port == PORT_D) ? d_addr  : c_addr;
      r_wdata <= (w_port == PORT_D) ? d_wdata : c_wdata;
    end
  end

  // A read is returning data during RSP (RAM data is valid the cycle after ram_read).
  assign w_rd_rsp = (r_state == ST_RSP) && !r_we;

  // Per-port read-data registers, loaded only when that port's read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else if (w_rd_rsp) begin
      if (r_port == PORT_D) begin
        r_d_rdata <= ram_rdata;
      end else begin
        r_c_rdata <= ram_rdata;
      end
    end
  end

  // Strobes, grants and done pulses decoded from state; read data is forwarded
  // during the done cycle so it is visible together with done, then held.
  always_comb begin
    ram_read  = 1'b0;
    ram_write = 1'b0;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    c_done    = 1'b0;
    d_done    = 1'b0;
    c_rdata   = r_c_rdata;
    d_rdata   = r_d_rdata;
    if (r_state == ST_ACC) begin
      ram_read  = !r_we;
      ram_write = r_we;
      c_gnt     = (r_port == PORT_C);
      d_gnt     = (r_port == PORT_D);
    end
    if (r_state == ST_RSP) begin
      c_done = (r_port == PORT_C);
      d_done = (r_port == PORT_D);
    end
    if (w_rd_rsp && (r_port == PORT_C)) c_rdata = ram_rdata;
    if (w_rd_rsp && (r_port == PORT_D)) d_rdata = ram_rdata;
  end

  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous RAM model.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic          c_gnt, c_done, d_gnt, d_done;
  logic [DW-1:0] c_rdata, d_rdata;
  logic          ram_read, ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:511];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // Synchronous RAM: read data appears the cycle after ram_read.
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    apply_reset();
    // Reset state
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_addr",  32'(ram_addr), 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_crd",   c_rdata, 32'd0);
    chk("rst_drd",   d_rdata, 32'd0);
    chk("rst_strb",  32'({ram_read, ram_write, c_gnt, d_gnt, c_done, d_done}), 32'd0);

    // CPU write 0x05A <- DEADBEEF
    c_req = 1; c_we = 1; c_addr = 9'h05A; c_wdata = 32'hDEADBEEF;
    tick();
    chk("w_acc_wr",   32'(ram_write), 32'd1);
    chk("w_acc_rd",   32'(ram_read), 32'd0);
    chk("w_acc_addr", 32'(ram_addr), 32'h05A);
    chk("w_acc_data", ram_wdata, 32'hDEADBEEF);
    chk("w_acc_cgnt", 32'(c_gnt), 32'd1);
    chk("w_acc_dq",   32'({d_gnt, d_done}), 32'd0);
    c_req = 0; c_addr = 9'h123; c_wdata = 32'h0;
    tick();
    chk("w_rsp_cdone", 32'(c_done), 32'd1);
    chk("w_rsp_strb",  32'({ram_write, c_gnt, d_done}), 32'd0);
    chk("w_rsp_hold",  32'(ram_addr), 32'h05A);
    tick();
    chk("w_idle", 32'({busy, c_done}), 32'd0);

    // CPU read 0x05A
    c_req = 1; c_we = 0; c_addr = 9'h05A;
    tick();
    chk("r_acc_rd",   32'({ram_read, ram_write, c_gnt}), 32'b101);
    chk("r_acc_addr", 32'(ram_addr), 32'h05A);
    c_req = 0;
    tick();
    chk("r_rsp_cdone", 32'(c_done), 32'd1);
    chk("r_rsp_crd",   c_rdata, 32'hDEADBEEF);
    chk("r_rsp_drd",   d_rdata, 32'd0);
    tick();
    chk("r_hold_crd", c_rdata, 32'hDEADBEEF);

    // Contention: both ports request continuously for 12 cycles
    apply_reset();
    c_req = 1; c_we = 1; c_addr = 9'h010; c_wdata = 32'h11;
    d_req = 1; d_we = 1; d_addr = 9'h020; d_wdata = 32'h22;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("rr_cgnt%0d", t), 32'(c_gnt), 32'(t == 1 || t == 7));
      chk($sformatf("rr_dgnt%0d", t), 32'(d_gnt), 32'(t == 4 || t == 10));
      chk($sformatf("rr_cdone%0d", t), 32'(c_done), 32'(t == 2 || t == 8));
      chk($sformatf("rr_busy%0d", t), 32'(busy), 32'((t % 3) != 0));
    end
    c_req = 0; d_req = 0;
    tick();
    chk("rr_quiet", 32'(busy), 32'd0);

    // D request pulsed during the CPU's ACC cycle is ignored
    c_req = 1; c_we = 0; c_addr = 9'h05A;
    tick();
    c_req = 0;
    d_req = 1; d_we = 1; d_addr = 9'h033; d_wdata = 32'h55;
    chk("pul_acc_dgnt", 32'(d_gnt), 32'd0);
    tick();
    d_req = 0;
    chk("pul_rsp_dgnt", 32'(d_gnt), 32'd0);
    chk("pul_rsp_crd",  c_rdata, 32'hDEADBEEF);
    tick();
    chk("pul_idle", 32'(busy), 32'd0);
    tick();
    chk("pul_no_d", 32'({busy, d_gnt}), 32'd0);

    // Reset during RSP of a read
    c_req = 1; c_we = 0; c_addr = 9'h05A;
    tick();
    c_req = 0;
    tick();
    rst = 1'b1;
    #1;
    chk("ar_cdone", 32'(c_done), 32'd0);
    chk("ar_busy",  32'(busy), 32'd0);
    chk("ar_addr",  32'(ram_addr), 32'd0);
    chk("ar_crd",   c_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    c_req = 1; c_we = 0; c_addr = 9'h05A;
    tick();
    chk("ar_resume_gnt", 32'(c_gnt), 32'd1);
    c_req = 0;
    tick();
    tick();

    // D write to top address, then C read back
    d_req = 1; d_we = 1; d_addr = 9'h1FF; d_wdata = 32'h12345678;
    tick();
    chk("top_w_addr", 32'(ram_addr), 32'h1FF);
    chk("top_w_strb", 32'({ram_write, d_gnt, c_gnt}), 32'b110);
    d_req = 0;
    tick();
    chk("top_w_ddone", 32'(d_done), 32'd1);
    tick();
    c_req = 1; c_we = 0; c_addr = 9'h1FF;
    tick();
    chk("top_r_addr", 32'(ram_addr), 32'h1FF);
    chk("top_r_rd",   32'(ram_read), 32'd1);
    c_req = 0;
    tick();
    chk("top_r_crd", c_rdata, 32'h12345678);
    chk("top_r_drd", d_rdata, 32'd0);
    tick();
    chk("top_r_hold", c_rdata, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
